// File: rtl/ibutterfly3_8.sv
// -----------------------------------------------------------------------------
// ibutterfly3_8
//
// Purpose:
//   Final inverse butterfly stage of an 8-point inverse transform. One row of
//   eight signed samples (even part E0..E3 on i_0..i_3, odd part O0..O3 on
//   i_4..i_7) is recombined into eight reconstructed samples:
//     o_k     = E_k + O_k     (k = 0..3)
//     o_(7-k) = E_k - O_k     (k = 0..3)
//   With enable=0 the row passes through unchanged. The block is a single
//   pipeline register with a valid/ready handshake on both sides, and it
//   flags the 8th output row of every 8x8 block on o_last.
//
// Configuration:
//   IBUTTERFLY_SAT_EN  defined   -> results saturate to the WIDTH-bit range
//                      undefined -> results wrap (two's complement, low bits)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   enable     in   1 = inverse butterfly, 0 = bypass (sampled with input row)
//   i_valid    in   input row valid
//   i_ready    out  block can accept an input row (combinational)
//   i_0..i_3   in   even part E0..E3, WIDTH-bit signed
//   i_4..i_7   in   odd part O0..O3, WIDTH-bit signed
//   o_valid    out  output row valid
//   o_ready    in   downstream accepts the output row
//   o_0..o_7   out  reconstructed samples, WIDTH-bit signed
//   o_last     out  high with the 8th output row of an 8x8 block
// -----------------------------------------------------------------------------
module ibutterfly3_8 #(
  parameter int WIDTH = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic signed [WIDTH-1:0] i_0,
  input  logic signed [WIDTH-1:0] i_1,
  input  logic signed [WIDTH-1:0] i_2,
  input  logic signed [WIDTH-1:0] i_3,
  input  logic signed [WIDTH-1:0] i_4,
  input  logic signed [WIDTH-1:0] i_5,
  input  logic signed [WIDTH-1:0] i_6,
  input  logic signed [WIDTH-1:0] i_7,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [WIDTH-1:0] o_0,
  output logic signed [WIDTH-1:0] o_1,
  output logic signed [WIDTH-1:0] o_2,
  output logic signed [WIDTH-1:0] o_3,
  output logic signed [WIDTH-1:0] o_4,
  output logic signed [WIDTH-1:0] o_5,
  output logic signed [WIDTH-1:0] o_6,
  output logic signed [WIDTH-1:0] o_7,
  output logic                    o_last
);

  // Two-state occupancy of the single output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic                    w_in_xfer;
  logic                    w_out_xfer;

  logic signed [WIDTH-1:0] w_in  [8];
  logic signed [WIDTH-1:0] w_res [8];
  logic signed [WIDTH-1:0] r_data [8];
  logic [2:0]              r_row_cnt;

  // ---------------------------------------------------------------------------
  // Input gathering
  // ---------------------------------------------------------------------------
  assign w_in[0] = i_0;
  assign w_in[1] = i_1;
  assign w_in[2] = i_2;
  assign w_in[3] = i_3;
  assign w_in[4] = i_4;
  assign w_in[5] = i_5;
  assign w_in[6] = i_6;
  assign w_in[7] = i_7;

`ifdef IBUTTERFLY_SAT_EN
  // Clamp a WIDTH+1-bit result into WIDTH bits. Overflow is exactly the case
  // where the two top bits disagree; the top bit then gives the direction.
  function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [WIDTH:0] x);
    logic signed [WIDTH-1:0] y;
    if (x[WIDTH] != x[WIDTH-1]) begin
      y = x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      y = x[WIDTH-1:0];
    end
    return y;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Butterfly datapath: lane gi pairs E_gi with O_gi and writes o_gi / o_(7-gi)
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bfly
      logic signed [WIDTH-1:0] w_sum_red;
      logic signed [WIDTH-1:0] w_diff_red;

`ifdef IBUTTERFLY_SAT_EN
      logic signed [WIDTH:0] w_sum;
      logic signed [WIDTH:0] w_diff;

      // One guard bit so the true result is always representable.
      assign w_sum      = {w_in[gi][WIDTH-1], w_in[gi]} + {w_in[gi+4][WIDTH-1], w_in[gi+4]};
      assign w_diff     = {w_in[gi][WIDTH-1], w_in[gi]} - {w_in[gi+4][WIDTH-1], w_in[gi+4]};
      assign w_sum_red  = sat_fn(w_sum);
      assign w_diff_red = sat_fn(w_diff);
`else
      // Wrapping build: the guard bit would be dropped anyway, so the low
      // WIDTH bits of a WIDTH-bit add are already the wrapped result.
      assign w_sum_red  = w_in[gi] + w_in[gi+4];
      assign w_diff_red = w_in[gi] - w_in[gi+4];
`endif

      assign w_res[gi]   = enable ? w_sum_red  : w_in[gi];
      assign w_res[7-gi] = enable ? w_diff_red : w_in[7-gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign w_in_xfer  = i_valid && i_ready;
  assign w_out_xfer = o_valid && o_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        // A simultaneous load keeps the register full (no bubble).
        if (w_out_xfer && !w_in_xfer) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_valid = (r_state == ST_FULL);
    // Accept when empty, or when the held row leaves this same cycle.
    i_ready = !o_valid || o_ready;
    o_last  = o_valid && (r_row_cnt == 3'd7);
  end

  // ---------------------------------------------------------------------------
  // Output data register: loads only on input transfer, so it holds during
  // backpressure and keeps the last row after it has been consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        r_data[k] <= '0;
      end
    end else if (w_in_xfer) begin
      for (int k = 0; k < 8; k++) begin
        r_data[k] <= w_res[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row counter: position of the currently presented row within its 8x8
  // block. Advances per consumed row, bypass rows included; 3 bits wrap 7->0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_cnt <= 3'd0;
    end else if (w_out_xfer) begin
      r_row_cnt <= r_row_cnt + 3'd1;
    end
  end

  assign o_0 = r_data[0];
  assign o_1 = r_data[1];
  assign o_2 = r_data[2];
  assign o_3 = r_data[3];
  assign o_4 = r_data[4];
  assign o_5 = r_data[5];
  assign o_6 = r_data[6];
  assign o_7 = r_data[7];

endmodule

// File: tb/tb_ibutterfly3_8.sv
// -----------------------------------------------------------------------------
// tb_ibutterfly3_8
//
// Self-checking bench for ibutterfly3_8 (WIDTH = 28). Honours the
// IBUTTERFLY_SAT_EN macro when forming expected results.
// -----------------------------------------------------------------------------
module tb_ibutterfly3_8;

  localparam int    W    = 28;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (W-1));
  localparam longint MODV = (64'sd1 <<< W);

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic i_valid;
  logic i_ready;
  logic o_valid;
  logic o_ready;
  logic o_last;
  logic signed [W-1:0] din  [8];
  logic signed [W-1:0] dout [8];
  logic signed [W-1:0] o_0, o_1, o_2, o_3, o_4, o_5, o_6, o_7;

  always #5 clk = ~clk;

  ibutterfly3_8 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_0     (din[0]),
    .i_1     (din[1]),
    .i_2     (din[2]),
    .i_3     (din[3]),
    .i_4     (din[4]),
    .i_5     (din[5]),
    .i_6     (din[6]),
    .i_7     (din[7]),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_0     (o_0),
    .o_1     (o_1),
    .o_2     (o_2),
    .o_3     (o_3),
    .o_4     (o_4),
    .o_5     (o_5),
    .o_6     (o_6),
    .o_7     (o_7),
    .o_last  (o_last)
  );

  assign dout[0] = o_0;
  assign dout[1] = o_1;
  assign dout[2] = o_2;
  assign dout[3] = o_3;
  assign dout[4] = o_4;
  assign dout[5] = o_5;
  assign dout[6] = o_6;
  assign dout[7] = o_7;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the block should be presenting.
  logic            m_valid = 1'b0;
  int              m_cnt   = 0;     // output rows consumed, modulo 8
  longint          m_data [8];

  // ---------------------------------------------------------------------------
  // Comparison and reference arithmetic
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Bring an exact integer result into the WIDTH-bit result range.
  function automatic longint reduce(input longint r);
    longint v;
    v = r;
`ifdef IBUTTERFLY_SAT_EN
    if (v > MAXV) v = MAXV;
    if (v < MINV) v = MINV;
`else
    while (v > MAXV) v = v - MODV;
    while (v < MINV) v = v + MODV;
`endif
    return v;
  endfunction

  // Expected output k for the row currently on din.
  function automatic longint ref_out(input int k, input logic en);
    longint a, b;
    if (!en) return longint'(din[k]);
    if (k < 4) begin
      a = din[k];
      b = din[k+4];
      return reduce(a + b);
    end
    a = din[7-k];
    b = din[11-k];
    return reduce(a - b);
  endfunction

  // ---------------------------------------------------------------------------
  // One clock cycle: predict the handshake, advance the model, check outputs.
  // ---------------------------------------------------------------------------
  task automatic step();
    logic   in_x;
    logic   out_x;
    longint nxt [8];
    @(negedge clk);
    chk("i_ready", i_ready, (!m_valid || o_ready) ? 1 : 0);
    in_x  = i_valid && (!m_valid || o_ready);
    out_x = m_valid && o_ready;
    for (int k = 0; k < 8; k++) nxt[k] = ref_out(k, enable);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_cnt   = 0;
      for (int k = 0; k < 8; k++) m_data[k] = 0;
    end else begin
      if (out_x) begin
        $display("out row cnt=%0d last=%0d o_0=%0d o_7=%0d", m_cnt, (m_cnt == 7), m_data[0], m_data[7]);
        m_cnt = (m_cnt + 1) % 8;
      end
      if (in_x) begin
        for (int k = 0; k < 8; k++) m_data[k] = nxt[k];
        m_valid = 1'b1;
        $display("in  row en=%0d i_0=%0d i_4=%0d", enable, din[0], din[4]);
      end else if (out_x) begin
        m_valid = 1'b0;
      end
    end
    chk("o_valid", o_valid, m_valid);
    chk("o_last", o_last, (m_valid && m_cnt == 7) ? 1 : 0);
    for (int k = 0; k < 8; k++) chk($sformatf("o_%0d", k), dout[k], m_data[k]);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic signed [W-1:0] rnd_sample();
    logic [31:0] u;
    u = $urandom;
    case (u[31:29])
      3'd0:    return MAXV[W-1:0];
      3'd1:    return MINV[W-1:0];
      default: return u[W-1:0];
    endcase
  endfunction

  task automatic rnd_row();
    for (int k = 0; k < 8; k++) din[k] = rnd_sample();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic         en;
    logic [8*W-1:0] din;
    logic [8*W-1:0] dexp;
  } vec_t;

  function automatic logic [8*W-1:0] p8(input longint a0, input longint a1, input longint a2,
                                         input longint a3, input longint a4, input longint a5,
                                         input longint a6, input longint a7);
    logic [8*W-1:0] r;
    r[0*W +: W] = a0[W-1:0];
    r[1*W +: W] = a1[W-1:0];
    r[2*W +: W] = a2[W-1:0];
    r[3*W +: W] = a3[W-1:0];
    r[4*W +: W] = a4[W-1:0];
    r[5*W +: W] = a5[W-1:0];
    r[6*W +: W] = a6[W-1:0];
    r[7*W +: W] = a7[W-1:0];
    return r;
  endfunction

  vec_t tbl [5];
  longint held [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din[k]    = '0;
      m_data[k] = 0;
    end

    // Basic butterfly example.
    tbl[0] = '{en: 1'b1, din: p8(100, -7, 0, 0, 30, 5, 0, 0),
               dexp: p8(130, -2, 0, 0, 0, 0, -12, 70)};
    // Bypass.
    tbl[1] = '{en: 1'b0, din: p8(1, 2, 3, 4, 5, 6, 7, 8),
               dexp: p8(1, 2, 3, 4, 5, 6, 7, 8)};
`ifdef IBUTTERFLY_SAT_EN
    // Positive overflow on o_0.
    tbl[2] = '{en: 1'b1, din: p8(MAXV, 0, 0, 0, 1, 0, 0, 0),
               dexp: p8(MAXV, 0, 0, 0, 0, 0, 0, MAXV - 1)};
    // Negative overflow on o_7.
    tbl[4] = '{en: 1'b1, din: p8(MINV, 0, 0, 0, 1, 0, 0, 0),
               dexp: p8(MINV + 1, 0, 0, 0, 0, 0, 0, MINV)};
`else
    tbl[2] = '{en: 1'b1, din: p8(MAXV, 0, 0, 0, 1, 0, 0, 0),
               dexp: p8(MINV, 0, 0, 0, 0, 0, 0, MAXV - 1)};
    tbl[4] = '{en: 1'b1, din: p8(MINV, 0, 0, 0, 1, 0, 0, 0),
               dexp: p8(MINV + 1, 0, 0, 0, 0, 0, 0, MAXV)};
`endif
    // Negative operands on lane 3.
    tbl[3] = '{en: 1'b1, din: p8(0, 0, 0, -5, 0, 0, 0, -8),
               dexp: p8(0, 0, 0, -13, 3, 0, 0, 0)};

    // Reset state (checked during reset via step()).
    do_reset();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_i_ready", i_ready, 1);

    // ---- table vectors ----
    for (int i = 0; i < 5; i++) begin
      enable  = tbl[i].en;
      for (int k = 0; k < 8; k++) din[k] = $signed(tbl[i].din[k*W +: W]);
      i_valid = 1'b1;
      o_ready = 1'b1;
      step();
      $display("vector %0d en=%0d o_0=%0d o_7=%0d", i, tbl[i].en, o_0, o_7);
      for (int k = 0; k < 8; k++)
        chk($sformatf("vec%0d_o_%0d", i, k), dout[k], $signed(tbl[i].dexp[k*W +: W]));
      chk($sformatf("vec%0d_valid", i), o_valid, 1);
      i_valid = 1'b0;
      step();
    end

    // ---- backpressure: hold 3 cycles, then stream with no bubble ----
    do_reset();
    enable  = 1'b1;
    rnd_row();
    i_valid = 1'b1;
    o_ready = 1'b0;
    step();
    for (int k = 0; k < 8; k++) held[k] = dout[k];
    rnd_row();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_i_ready", i_ready, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("bp_hold_o_%0d", k), dout[k], held[k]);
    end
    o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_stream_valid", o_valid, 1);
      rnd_row();
    end
    i_valid = 1'b0;
    step();
    chk("bp_drained", o_valid, 0);

    // ---- o_last on 8th of 9 back-to-back rows ----
    do_reset();
    o_ready = 1'b1;
    i_valid = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      enable = r[0];
      rnd_row();
      step();
      chk($sformatf("last_row%0d", r), o_last, (r == 8) ? 1 : 0);
    end
    i_valid = 1'b0;
    step();

    // ---- reset mid-operation ----
    do_reset();
    i_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rnd_row();
      step();
    end
    chk("mid_valid_before", o_valid, 1);
    rst_n   = 1'b0;
    i_valid = 1'b0;
    step();
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_o_0", o_0, 0);
    chk("mid_rst_o_7", o_7, 0);
    rst_n   = 1'b1;
    i_valid = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      rnd_row();
      step();
      chk($sformatf("mid_last_row%0d", r), o_last, (r == 8) ? 1 : 0);
    end
    i_valid = 1'b0;
    step();

    // ---- randomized traffic against the reference model ----
    for (int c = 0; c < 600; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 2) != 0);
      enable  = $urandom_range(0, 1) != 0;
      rst_n   = ($urandom_range(0, 99) != 0);
      rnd_row();
      step();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
